// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
//
// Picks the write-back datum from the MEM/WB outputs with priority
// jal > memToReg > ALU. It commits that datum to a 2**ASIZE-entry register
// file, where r0 is hardwired to zero. It also serves two combinational read
// ports to decode.
//
// For EX forwarding, it registers a one-cycle status of the last committed
// write (valid/addr/data). It also keeps a wrapping count of committed writes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   alu_result_in_WB    ALU result
//   rdata_DM_in_WB      data-memory read data
//   memToReg_in_WB      select memory data over ALU result
//   jal_in_WB           select npc (return address); overrides memToReg
//   npc_in_WB           return address, zero-extended/truncated to DSIZE
//   waddr_in_WB         destination register
//   WriteEn_in_WB       write request
//   raddr1/2, rdata1/2  combinational read ports
//   wb_valid_out        a commit happened on the last edge
//   wb_addr_out/data    address/data of the most recent commit (held)
//   wr_count            committed-write counter, wraps
//
// Build option: define WB_BYPASS_EN to make a read that hits the register
// being committed this cycle return the new datum (write-through).
// Without it, the read returns the old contents.
module wb_regfile #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32,
  parameter int CSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] alu_result_in_WB,
  input  logic [DSIZE-1:0] rdata_DM_in_WB,
  input  logic             memToReg_in_WB,
  input  logic             jal_in_WB,
  input  logic [ISIZE-1:0] npc_in_WB,
  input  logic [ASIZE-1:0] waddr_in_WB,
  input  logic             WriteEn_in_WB,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  output logic             wb_valid_out,
  output logic [ASIZE-1:0] wb_addr_out,
  output logic [DSIZE-1:0] wb_data_out,
  output logic [CSIZE-1:0] wr_count
);

  localparam int NREG = 1 << ASIZE;

  logic [NREG-1:0][DSIZE-1:0] regs_q, regs_d;
  logic                       wb_valid_q, wb_valid_d;
  logic [ASIZE-1:0]           wb_addr_q, wb_addr_d;
  logic [DSIZE-1:0]           wb_data_q, wb_data_d;
  logic [CSIZE-1:0]           cnt_q, cnt_d;

  logic [DSIZE-1:0] npc_ext;
  logic [DSIZE-1:0] wdata;
  logic             commit;

  // Fit the return address to the data width (keep LSBs / zero-extend).
  generate
    if (ISIZE >= DSIZE) begin : g_npc_trunc
      assign npc_ext = npc_in_WB[DSIZE-1:0];
    end else begin : g_npc_zext
      assign npc_ext = {{(DSIZE-ISIZE){1'b0}}, npc_in_WB};
    end
  endgenerate

  always_comb begin
    wdata = alu_result_in_WB;
    if (jal_in_WB)           wdata = npc_ext;
    else if (memToReg_in_WB) wdata = rdata_DM_in_WB;
  end

  // Writes to r0 are dropped entirely: no array update, no status, no count.
  assign commit = WriteEn_in_WB && (waddr_in_WB != '0);

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[waddr_in_WB] = wdata;
    regs_d[0] = '0;
  end

  always_comb begin
    wb_valid_d = commit;
    wb_addr_d  = commit ? waddr_in_WB : wb_addr_q;
    wb_data_d  = commit ? wdata       : wb_data_q;
    cnt_d      = cnt_q + CSIZE'(commit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Read ports. Reset forces 0 explicitly so that, with bypass enabled, an
  // in-flight write cannot leak through while rst is held.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
`ifdef WB_BYPASS_EN
    if (commit && (raddr1 == waddr_in_WB)) rdata1 = wdata;
    if (commit && (raddr2 == waddr_in_WB)) rdata2 = wdata;
`endif
    if (rst || raddr1 == '0) rdata1 = '0;
    if (rst || raddr2 == '0) rdata2 = '0;
  end

  assign wb_valid_out = wb_valid_q;
  assign wb_addr_out  = wb_addr_q;
  assign wb_data_out  = wb_data_q;
  assign wr_count     = cnt_q;

endmodule
